// File: rtl/shift_unit_seq.sv
// Iterative shift/rotate engine: shifts the operand one bit per clock and
// presents a registered result with a one-cycle done pulse.
module shift_unit_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [31:0]      num_shifts,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHRA = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;

    state_t             state, state_d;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;

    logic               too_big;
    logic [WIDTH-1:0]   load_acc;
    logic [CNT_W-1:0]   load_cnt;
    logic [WIDTH-1:0]   step_val;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Operand and effective count captured when a start is accepted.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        too_big  = (num_shifts >= 32'(WIDTH));
        load_acc = data_in;
        load_cnt = num_shifts[CNT_W-1:0];
        case (op)
            OP_SHL, OP_SHR: begin
                if (too_big) begin
                    load_acc = '0;
                    load_cnt = '0;
                end
            end
            OP_SHRA: begin
                if (too_big) load_cnt = CNT_W'(WIDTH - 1);
            end
            OP_ROL, OP_ROR: ;
            default: load_cnt = '0;
        endcase
    end

    always_comb begin
        step_val = acc;
        case (op_q)
            OP_SHL:  step_val = {acc[WIDTH-2:0], 1'b0};
            OP_SHR:  step_val = {1'b0, acc[WIDTH-1:1]};
            OP_SHRA: step_val = {acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_ROL:  step_val = {acc[WIDTH-2:0], acc[WIDTH-1]};
            OP_ROR:  step_val = {acc[0], acc[WIDTH-1:1]};
            default: step_val = acc;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (start) state_d = (load_cnt == '0) ? DONE : RUN;
            RUN:  if (cnt == CNT_W'(1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (clear) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            acc  <= '0;
            cnt  <= '0;
            op_q <= '0;
            out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= load_acc;
                        op_q <= op;
                        cnt  <= load_cnt;
                        if (load_cnt == '0) out <= load_acc;
                    end
                end
                RUN: begin
                    acc <= step_val;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) out <= step_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed self-checking bench for shift_unit_seq: results, latency, busy
// span, ignored starts and mid-run clear.
module tb_shift_unit_seq;

    localparam int WIDTH = 32;

    logic             clock;
    logic             clear;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [31:0]      num_shifts;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;

    int n_pass  = 0;
    int n_total = 0;
    logic [WIDTH-1:0] last_out = '0;

    shift_unit_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .op         (op),
        .data_in    (data_in),
        .num_shifts (num_shifts),
        .busy       (busy),
        .done       (done),
        .out        (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Accepts one operation and follows it to done; n_eff is the hand-derived
    // effective count, so done must appear n_eff+1 edges after acceptance.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] d,
                          input logic [31:0] n, input int n_eff, input logic [31:0] exp_out);
        int k;
        int busy_cycles;
        bit seen;
        busy_cycles = 0;
        seen = 0;
        @(negedge clock);
        op = o; data_in = d; num_shifts = n; start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        data_in = ~d;
        num_shifts = 32'd3;
        op = 3'b001;
        for (k = 1; k <= WIDTH + 4; k++) begin
            @(negedge clock);
            if (k == 1 && n_eff > 0) check({tag, " out_hold"}, out, last_out);
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) k = WIDTH + 5;
        check({tag, " latency"}, 32'(k), 32'(n_eff + 1));
        check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(n_eff + 1));
        check({tag, " out"}, out, exp_out);
        @(negedge clock);
        check({tag, " idle"}, {30'd0, busy, done}, 32'd0);
        last_out = exp_out;
    endtask

    initial begin
        int pulses;
        clear = 1'b1; start = 1'b0; op = '0; data_in = '0; num_shifts = '0;
        repeat (2) @(negedge clock);
        check("reset outputs", {out[29:0], busy, done}, 32'd0);
        check("reset out", out, 32'd0);
        clear = 1'b0;

        run_op("shl2",      3'b000, 32'hFFFF_FFF0, 32'd2,   2,  32'hFFFF_FFC0);
        run_op("shra4",     3'b010, 32'h8000_0000, 32'd4,   4,  32'hF800_0000);
        run_op("shra100",   3'b010, 32'h8000_0000, 32'd100, 31, 32'hFFFF_FFFF);
        run_op("shra100p",  3'b010, 32'h4000_0000, 32'd100, 31, 32'h0000_0000);
        run_op("ror1",      3'b100, 32'h0000_0001, 32'd1,   1,  32'h8000_0000);
        run_op("rol33",     3'b011, 32'h0000_0001, 32'd33,  1,  32'h0000_0002);
        run_op("rol4",      3'b011, 32'h8000_0001, 32'd4,   4,  32'h0000_0018);
        run_op("shr4",      3'b001, 32'hF000_0000, 32'd4,   4,  32'h0F00_0000);
        run_op("shl40",     3'b000, 32'h1234_5678, 32'd40,  0,  32'h0000_0000);
        run_op("shr0",      3'b001, 32'h1234_5678, 32'd0,   0,  32'h1234_5678);
        run_op("illegal",   3'b111, 32'hDEAD_BEEF, 32'd7,   0,  32'hDEAD_BEEF);
        run_op("shr32",     3'b001, 32'hFFFF_FFFF, 32'd32,  0,  32'h0000_0000);

        // Second start mid-run must be dropped; first result survives.
        @(negedge clock);
        op = 3'b001; data_in = 32'hA5A5_A5A5; num_shifts = 32'd20; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        op = 3'b000; data_in = 32'hFFFF_FFFF; num_shifts = 32'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("ignored busy", {31'd0, busy}, 32'd1);
        check("ignored out_hold", out, last_out);
        pulses = 0;
        for (int i = 0; i < 30 && pulses == 0; i++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("ignored done seen", 32'(pulses), 32'd1);
        check("ignored out", out, 32'h0000_0A5A);
        @(negedge clock);
        check("ignored no requeue", {30'd0, busy, done}, 32'd0);

        // Clear in the middle of a 20-shift run aborts it outright.
        op = 3'b000; data_in = 32'h0000_0001; num_shifts = 32'd20; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("pre-clear busy", {31'd0, busy}, 32'd1);
        clear = 1'b1;
        #1;
        check("clear out", out, 32'd0);
        check("clear busy_done", {30'd0, busy, done}, 32'd0);
        @(negedge clock);
        clear = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (done || busy) pulses++;
        end
        check("post-clear quiet", 32'(pulses), 32'd0);
        last_out = '0;
        run_op("after clear", 3'b100, 32'h0000_0002, 32'd1, 1, 32'h0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
